// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller for a MIPS-subset datapath: FETCH/DECODE/EXE/MEM/WB.
// Strobes and selects decode from state and IR; retire, mem_err are registered.
module multi_cycle_ctrl #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               zero,
   input  logic               gtz,
   input  logic               mem_ready,
   output logic               PC_Write,
   output logic               IR_Write,
   output logic               GPR_Write,
   output logic               DM_Write,
   output logic               DM_Read,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemToReg,
   output logic [1:0]         ExtOp,
   output logic [1:0]         NPCOp,
   output logic               AluSrc,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [2:0]         state,
   output logic               retire,
   output logic               illegal,
   output logic               mem_err
);

   localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_retire;
   logic          r_mem_err;

   logic [5:0] w_op;
   logic [5:0] w_fn;
   logic       w_unused;
   logic       w_r;
   logic       w_addu;
   logic       w_subu;
   logic       w_sll;
   logic       w_jr;
   logic       w_ori;
   logic       w_lw;
   logic       w_sw;
   logic       w_beq;
   logic       w_bgtz;
   logic       w_jal;
   logic       w_lui;
   logic       w_legal;
   logic       w_rtype;
   logic       w_imm;
   logic       w_tmo;
   logic [1:0] w_alu;

   assign w_op     = instr[31:26];
   assign w_fn     = instr[5:0];
   assign w_unused = ^instr[25:6];

   assign w_r    = (w_op == 6'h00);
   assign w_addu = w_r && (w_fn == 6'h21);
   assign w_subu = w_r && (w_fn == 6'h23);
   assign w_sll  = w_r && (w_fn == 6'h00);
   assign w_jr   = w_r && (w_fn == 6'h08);
   assign w_ori  = (w_op == 6'h0D);
   assign w_lw   = (w_op == 6'h23);
   assign w_sw   = (w_op == 6'h2B);
   assign w_beq  = (w_op == 6'h04);
   assign w_bgtz = (w_op == 6'h07);
   assign w_jal  = (w_op == 6'h03);
   assign w_lui  = (w_op == 6'h0F);

   assign w_rtype = w_addu | w_subu | w_sll;
   assign w_imm   = w_ori | w_lui | w_lw | w_sw;
   assign w_legal = w_rtype | w_jr | w_imm | w_beq
                  | w_bgtz | w_jal;

   assign w_alu = (w_subu | w_beq) ? 2'd1 :
                  w_ori            ? 2'd2 :
                  w_sll            ? 2'd3 : 2'd0;

   // r_cnt holds MEM cycles already spent, so TMO_LAST marks the final one
   assign w_tmo = (r_cnt >= TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FETCH;
         r_cnt     <= '0;
         r_retire  <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            FETCH: r_state <= DECODE;
            DECODE: begin
               if (w_jal || w_jr) begin
                  r_state  <= FETCH;
                  r_retire <= 1'b1;
               end else if (!w_legal) begin
                  r_state <= FETCH;
               end else begin
                  r_state <= EXE;
               end
            end
            EXE: begin
               r_cnt <= '0;
               if (w_beq || w_bgtz) begin
                  r_state  <= FETCH;
                  r_retire <= 1'b1;
               end else if (w_lw || w_sw) begin
                  r_state <= MEM;
               end else begin
                  r_state <= WB;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  if (w_sw) begin
                     r_state  <= FETCH;
                     r_retire <= 1'b1;
                  end else begin
                     r_state <= WB;
                  end
               end else if (w_tmo) begin
                  r_state   <= FETCH;
                  r_mem_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            WB: begin
               r_state  <= FETCH;
               r_retire <= 1'b1;
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   // reset gates everything so a mid-access abort drops strobes at once
   always_comb begin
      PC_Write  = 1'b0;
      IR_Write  = 1'b0;
      GPR_Write = 1'b0;
      DM_Write  = 1'b0;
      DM_Read   = 1'b0;
      RegDst    = 2'd0;
      MemToReg  = 2'd0;
      ExtOp     = 2'd0;
      NPCOp     = 2'd0;
      AluSrc    = 1'b0;
      ALUOp     = '0;
      illegal   = 1'b0;
      if (!reset) begin
         case (r_state)
            FETCH: begin
               IR_Write = 1'b1;
               PC_Write = 1'b1;
            end
            DECODE: begin
               if (w_jal) begin
                  GPR_Write = 1'b1;
                  RegDst    = 2'd2;
                  MemToReg  = 2'd2;
                  PC_Write  = 1'b1;
                  NPCOp     = 2'd2;
               end else if (w_jr) begin
                  PC_Write = 1'b1;
                  NPCOp    = 2'd3;
               end else if (!w_legal) begin
                  illegal = 1'b1;
               end
            end
            EXE, MEM, WB: begin
               RegDst   = {1'b0, w_rtype};
               AluSrc   = w_imm;
               MemToReg = {1'b0, w_lw};
               ExtOp    = w_lui ? 2'd2 : {1'b0, w_lw | w_sw};
               ALUOp    = ALUOP_W'(w_alu);
               if (r_state == EXE && (w_beq || w_bgtz)) begin
                  PC_Write = w_beq ? zero : gtz;
                  NPCOp    = 2'd1;
               end
               DM_Read   = (r_state == MEM) && w_lw;
               DM_Write  = (r_state == MEM) && w_sw;
               GPR_Write = (r_state == WB);
            end
            default: ;
         endcase
      end
   end

   assign state   = r_state;
   assign retire  = r_retire;
   assign mem_err = r_mem_err;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle output vectors per scenario.
// Vector = {state, IR,PC,GPR,DMW,DMR, NPCOp, retire,illegal,mem_err, selects}.
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        gtz = 1'b0;
   logic        mem_ready = 1'b0;
   logic        PC_Write, IR_Write, GPR_Write, DM_Write, DM_Read;
   logic [1:0]  RegDst, MemToReg, ExtOp, NPCOp;
   logic        AluSrc;
   logic [2:0]  ALUOp;
   logic [2:0]  state;
   logic        retire, illegal, mem_err;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [9:0]  S0   = '0;
   localparam logic [22:0] MALL = '1;
   localparam logic [22:0] MTOP = 23'h7FFC00;
   localparam logic [22:0] MNOA = 23'h7FFFF8;

   multi_cycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .zero(zero), .gtz(gtz), .mem_ready(mem_ready),
      .PC_Write(PC_Write), .IR_Write(IR_Write),
      .GPR_Write(GPR_Write), .DM_Write(DM_Write),
      .DM_Read(DM_Read), .RegDst(RegDst),
      .MemToReg(MemToReg), .ExtOp(ExtOp), .NPCOp(NPCOp),
      .AluSrc(AluSrc), .ALUOp(ALUOp), .state(state),
      .retire(retire), .illegal(illegal), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] sv(int rd, int as, int m2r,
                                     int ext, int alu);
      return {2'(rd), 1'(as), 2'(m2r), 2'(ext), 3'(alu)};
   endfunction

   function automatic logic [22:0] ev(int st, logic [4:0] stb,
                                      int npc, logic [2:0] fl,
                                      logic [9:0] sl);
      return {3'(st), stb, 2'(npc), fl, sl};
   endfunction

   function automatic logic [22:0] obs();
      return {state, IR_Write, PC_Write, GPR_Write, DM_Write,
              DM_Read, NPCOp, retire, illegal, mem_err,
              RegDst, AluSrc, MemToReg, ExtOp, ALUOp};
   endfunction

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic pulse_reset(input logic [31:0] v);
      @(negedge clk);
      instr = v;
      zero = 1'b0;
      gtz = 1'b0;
      mem_ready = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [22:0] e;
      @(negedge clk);
      instr = 32'h00221821;
      mem_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      e = ev(0, 5'b00000, 0, 3'b000, S0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want %h", obs(), e);
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      e = ev(0, 5'b11000, 0, 3'b000, S0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", obs(), e);
      end
      tick();
      e = ev(1, 5'b00000, 0, 3'b000, S0);
      n_tests++;
      if (obs() !== e) begin
         n_fail++;
         $display("FAIL reset_decode: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_addu();
      logic [22:0] e [6];
      logic [9:0]  s;
      s = sv(1, 0, 0, 0, 0);
      e = '{ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b00000, 0, 3'b000, S0),
            ev(2, 5'b00000, 0, 3'b000, s),
            ev(4, 5'b00100, 0, 3'b000, s),
            ev(0, 5'b11000, 0, 3'b100, S0),
            ev(1, 5'b00000, 0, 3'b000, S0)};
      pulse_reset(32'h00221821);
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (obs() !== e[i]) begin
            n_fail++;
            $display("FAIL addu c%0d: got %h want %h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_lw_wait();
      logic [22:0] e [9];
      logic [9:0]  s;
      s = sv(0, 1, 1, 1, 0);
      e = '{ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b00000, 0, 3'b000, S0),
            ev(2, 5'b00000, 0, 3'b000, s),
            ev(3, 5'b00001, 0, 3'b000, s),
            ev(3, 5'b00001, 0, 3'b000, s),
            ev(3, 5'b00001, 0, 3'b000, s),
            ev(3, 5'b00001, 0, 3'b000, s),
            ev(4, 5'b00100, 0, 3'b000, s),
            ev(0, 5'b11000, 0, 3'b100, S0)};
      pulse_reset(32'h8C220004);
      for (int i = 0; i < 9; i++) begin
         mem_ready = (i == 6);
         n_tests++;
         if (obs() !== e[i]) begin
            n_fail++;
            $display("FAIL lw_wait c%0d: got %h want %h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_sw_timeout();
      logic [22:0] e;
      logic [9:0]  s;
      s = sv(0, 1, 0, 1, 0);
      pulse_reset(32'hAC220004);
      for (int i = 0; i < 23; i++) begin
         mem_ready = (i == 21);
         if (i == 0)
            e = ev(0, 5'b11000, 0, 3'b000, S0);
         else if (i == 1)
            e = ev(1, 5'b00000, 0, 3'b000, S0);
         else if (i == 2)
            e = ev(2, 5'b00000, 0, 3'b000, s);
         else if (i <= 17)
            e = ev(3, 5'b00010, 0, 3'b000, s);
         else if (i == 18)
            e = ev(0, 5'b11000, 0, 3'b001, S0);
         else if (i == 19)
            e = ev(1, 5'b00000, 0, 3'b001, S0);
         else if (i == 20)
            e = ev(2, 5'b00000, 0, 3'b001, s);
         else if (i == 21)
            e = ev(3, 5'b00010, 0, 3'b001, s);
         else
            e = ev(0, 5'b11000, 0, 3'b101, S0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL sw_timeout c%0d: got %h want %h", i, obs(), e);
         end
         tick();
      end
   endtask

   task automatic test_timeout_edge();
      logic [22:0] e;
      logic [9:0]  s;
      s = sv(0, 1, 1, 1, 0);
      pulse_reset(32'h8C220004);
      for (int i = 0; i < 20; i++) begin
         mem_ready = (i == 17);
         if (i == 0)
            e = ev(0, 5'b11000, 0, 3'b000, S0);
         else if (i == 1)
            e = ev(1, 5'b00000, 0, 3'b000, S0);
         else if (i == 2)
            e = ev(2, 5'b00000, 0, 3'b000, s);
         else if (i <= 17)
            e = ev(3, 5'b00001, 0, 3'b000, s);
         else if (i == 18)
            e = ev(4, 5'b00100, 0, 3'b000, s);
         else
            e = ev(0, 5'b11000, 0, 3'b100, S0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL tmo_edge c%0d: got %h want %h", i, obs(), e);
         end
         tick();
      end
   endtask

   task automatic test_branches();
      logic [22:0] e [7];
      logic [22:0] m;
      logic [9:0]  s;
      for (int b = 0; b < 2; b++) begin
         s = (b == 0) ? sv(0, 0, 0, 0, 1) : S0;
         m = (b == 0) ? MALL : MTOP;
         e = '{ev(0, 5'b11000, 0, 3'b000, S0),
               ev(1, 5'b00000, 0, 3'b000, S0),
               ev(2, 5'b01000, 1, 3'b000, s),
               ev(0, 5'b11000, 0, 3'b100, S0),
               ev(1, 5'b00000, 0, 3'b000, S0),
               ev(2, 5'b00000, 1, 3'b000, s),
               ev(0, 5'b11000, 0, 3'b100, S0)};
         pulse_reset((b == 0) ? 32'h10220003 : 32'h1C200002);
         for (int i = 0; i < 7; i++) begin
            zero = (b == 0) && (i < 3);
            gtz  = (b == 1) && (i < 3);
            n_tests++;
            if ((obs() & m) !== (e[i] & m)) begin
               n_fail++;
               $display("FAIL branch%0d c%0d: got %h want %h",
                        b, i, obs() & m, e[i] & m);
            end
            tick();
         end
      end
   endtask

   task automatic test_jal_jr();
      logic [22:0] e [5];
      e = '{ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b01100, 2, 3'b000, sv(2, 0, 2, 0, 0)),
            ev(0, 5'b11000, 0, 3'b100, S0),
            ev(1, 5'b01000, 3, 3'b000, S0),
            ev(0, 5'b11000, 0, 3'b100, S0)};
      pulse_reset(32'h0C000010);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (obs() !== e[i]) begin
            n_fail++;
            $display("FAIL jal_jr c%0d: got %h want %h", i, obs(), e[i]);
         end
         if (i == 2) instr = 32'h03E00008;
         tick();
      end
   endtask

   task automatic test_alu_ops();
      logic [31:0] ins [4];
      logic [9:0]  sl [4];
      logic [22:0] mk [4];
      logic [22:0] e [3];
      ins = '{32'h34220005, 32'h3C021234, 32'h00221823, 32'h00021080};
      sl  = '{sv(0, 1, 0, 0, 2), sv(0, 1, 0, 2, 0),
              sv(1, 0, 0, 0, 1), sv(1, 0, 0, 0, 3)};
      mk  = '{MALL, MNOA, MALL, MALL};
      for (int k = 0; k < 4; k++) begin
         e = '{ev(2, 5'b00000, 0, 3'b000, sl[k]),
               ev(4, 5'b00100, 0, 3'b000, sl[k]),
               ev(0, 5'b11000, 0, 3'b100, S0)};
         pulse_reset(ins[k]);
         tick();
         for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ((obs() & mk[k]) !== (e[i] & mk[k])) begin
               n_fail++;
               $display("FAIL alu_op%0d c%0d: got %h want %h",
                        k, i + 2, obs() & mk[k], e[i] & mk[k]);
            end
         end
      end
   endtask

   task automatic test_illegal_reset();
      logic [22:0] e [8];
      logic [22:0] x;
      logic [9:0]  s;
      s = sv(0, 1, 1, 1, 0);
      e = '{ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b00000, 0, 3'b010, S0),
            ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b00000, 0, 3'b010, S0),
            ev(0, 5'b11000, 0, 3'b000, S0),
            ev(1, 5'b00000, 0, 3'b000, S0),
            ev(2, 5'b00000, 0, 3'b000, s),
            ev(3, 5'b00001, 0, 3'b000, s)};
      pulse_reset(32'hFC000000);
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (obs() !== e[i]) begin
            n_fail++;
            $display("FAIL illegal c%0d: got %h want %h", i, obs(), e[i]);
         end
         if (i == 2) instr = 32'h00221820;
         if (i == 4) instr = 32'h8C220004;
         if (i < 7) tick();
      end
      #1 reset = 1'b1;
      #1;
      x = ev(0, 5'b00000, 0, 3'b000, S0);
      n_tests++;
      if (obs() !== x) begin
         n_fail++;
         $display("FAIL abort_async: got %h want %h", obs(), x);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      x = ev(0, 5'b11000, 0, 3'b000, S0);
      n_tests++;
      if (obs() !== x) begin
         n_fail++;
         $display("FAIL abort_release: got %h want %h", obs(), x);
      end
   endtask

   initial begin
      test_reset();
      test_addu();
      test_lw_wait();
      test_sw_timeout();
      test_timeout_edge();
      test_branches();
      test_jal_jr();
      test_alu_ops();
      test_illegal_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, meaning width of the ALUOp output (minimum 3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state cycles spent waiting for mem_ready.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port instr, input, 32, the IR contents, valid from DECODE onward.
REQ-006 SHALL have ports zero and gtz, input, 1 each: ALU A==B, and signed A>0.
REQ-007 SHALL have port mem_ready, input, 1, data-memory completion for the current access.
REQ-008 SHALL have ports PC_Write, IR_Write, GPR_Write, DM_Write and DM_Read, output, 1 each: write/read strobes.
REQ-009 SHALL have ports RegDst, MemToReg, ExtOp and NPCOp, output, 2 each, with encodings:
- RegDst: 0=rt, 1=rd, 2=$31.
- MemToReg: 0=ALU, 1=DM, 2=PC+4.
- ExtOp: 0=zero, 1=sign, 2=lui.
- NPCOp: 0=PC+4, 1=branch, 2=jal, 3=jr.
REQ-010 SHALL have ports AluSrc, output, 1, and ALUOp, output, ALUOP_W.
- ALUOp values: 0=add, 1=sub, 2=or, 3=sll; upper bits 0.
REQ-011 SHALL have ports state, output, 3; retire, output, 1; illegal, output, 1; mem_err, output, 1.

Function
REQ-012 SHALL decode ori, lw, sw, beq, bgtz, jal, jr, addu, subu, lui and sll; any other encoding is illegal.
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXE=2, MEM=3 and WB=4; encodings 5-7 SHALL go to FETCH on the next clock.
REQ-014 SHALL behave in FETCH as follows:
- Outputs: IR_Write=1, PC_Write=1, NPCOp=0.
- Next state: DECODE.
REQ-015 SHALL behave in DECODE as follows:
- jal: GPR_Write=1, RegDst=2, MemToReg=2, PC_Write=1, NPCOp=2; next state FETCH.
- jr: PC_Write=1, NPCOp=3; next state FETCH.
- illegal: illegal=1 for one cycle, no strobes; next state FETCH.
- All other instructions: next state EXE.
REQ-016 SHALL behave in EXE as follows:
- beq: PC_Write=zero, NPCOp=1, ALUOp=sub; next state FETCH.
- bgtz: PC_Write=gtz, NPCOp=1; next state FETCH.
- lw/sw: AluSrc=1, ExtOp=1, ALUOp=add; next state MEM.
- addu/subu/sll/ori/lui: next state WB.
REQ-017 SHALL behave in MEM as follows:
- Hold DM_Read (lw) or DM_Write (sw) high every cycle until mem_ready=1.
- On mem_ready, sw goes to FETCH and lw goes to WB.
REQ-018 SHALL count MEM cycles in a counter cleared on MEM entry.
- If the counter reaches MEM_TIMEOUT without mem_ready, go to FETCH, set sticky mem_err and drop the strobe.
- mem_err is cleared only by reset.
REQ-019 SHALL, in WB, assert GPR_Write=1 with RegDst=1 for R-type and 0 otherwise, and MemToReg=1 for lw; next state FETCH.
REQ-020 SHALL hold datapath selects (RegDst, AluSrc, MemToReg, ExtOp, ALUOp) stable from EXE through WB of one instruction.
REQ-021 SHALL set selects to 0 in FETCH and for illegal instructions.
REQ-022 SHALL pulse retire for one cycle on each transition into FETCH caused by a completed instruction.
- retire SHALL NOT pulse on illegal or timeout.
REQ-023 SHALL give these cycle counts with mem_ready=1 on first MEM cycle:
- jal/jr: 2.
- beq/bgtz: 3.
- sw, addu, subu, sll, ori, lui: 4.
- lw: 5.
REQ-024 SHALL treat mem_ready=1 outside MEM as don't-care.
REQ-025 SHALL have mem_ready arriving on the timeout cycle take precedence over timeout.

Reset
REQ-026 SHALL, while reset=1, force state=FETCH, all strobes, retire and illegal to 0, and mem_err to 0, with the MEM counter cleared.
REQ-027 SHALL, on reset assertion mid-instruction, abort immediately with no further strobes.
- The first cycle after release is FETCH with IR_Write=1.

Verification
REQ-028 addu $3,$1,$2 (0x00221821) -> states 0,1,2,4.
- GPR_Write=1 and RegDst=1 in WB only; retire on return to FETCH.
REQ-029 lw with mem_ready low 3 cycles, then high -> DM_Read high for 4 MEM cycles.
- Then WB with MemToReg=1; total 8 cycles; mem_err=0.
REQ-030 sw with mem_ready never high, MEM_TIMEOUT=15 -> DM_Write high for 15 cycles.
- Then FETCH, mem_err=1 sticky, no retire.
REQ-031 beq with zero=1, then beq with zero=0 -> PC_Write=1 and NPCOp=1 in EXE for the first; PC_Write=0 for the second; 3 cycles each.
REQ-032 Opcode 0x3F, then reset asserted in MEM of a lw -> illegal pulses in DECODE with no strobes.
- On reset, DM_Read drops asynchronously; after release, FETCH with IR_Write=1.
